// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on {acc, sr}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sr_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem  = {acc, sr[WIDTH-1]};
    diff = rem - {1'b0, opnd};
    acc_nxt = acc;
    sr_nxt  = sr;
    if (is_div) begin
      // borrow out means the trial subtraction failed: restore and shift in a 0
      if (diff[WIDTH]) begin
        acc_nxt = rem[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = diff[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      sr_nxt  = {sum[0], sr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO with private HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// RUN   | one multiply/divide step per cycle on magnitudes
// FIX   | apply sign correction, write hi/lo, pulse done next cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mfreq,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  md_state_t state, state_nxt;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   acc, sr, opnd;
  logic [WIDTH-1:0]   acc_nxt, sr_nxt;
  logic               is_div, neg_q, neg_r, div0;
  logic               is_md, is_div_op, is_sgn, take, fin;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    is_md     = is_div_op || (op == MD_MULT) || (op == MD_MULTU);
    is_sgn    = (op == MD_MULT) || (op == MD_DIV);
    abs_a     = (is_sgn && a[WIDTH-1]) ? -a : a;
    abs_b     = (is_sgn && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush && is_md) begin
          take      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush)            state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        fin       = !flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .sr      (sr),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .sr_nxt  (sr_nxt)
  );

  // Divide by zero leaves acc holding |a|, so the dividend-sign fixup restores a into hi.
  always_comb begin
    prod     = {acc, sr};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = div0 ? {WIDTH{1'b1}} : (neg_q ? -sr : sr);
    rem_fix  = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      sr     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= fin;
      if (take) begin
        cnt    <= '0;
        acc    <= '0;
        sr     <= abs_a;
        opnd   <= abs_b;
        is_div <= is_div_op;
        neg_q  <= is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= is_sgn && a[WIDTH-1];
        div0   <= (b == '0);
      end else if (state == RUN) begin
        cnt <= cnt + CNTW'(1);
        acc <= acc_nxt;
        sr  <= sr_nxt;
      end
      if (state == IDLE && start && !flush) begin
        if (op == MD_MTHI) hi <= a;
        if (op == MD_MTLO) lo <= a;
      end
      if (fin) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mfreq);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of {hi,lo} results from a behavioural model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, mfreq;
  md_op_t      op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .mfreq (mfreq),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result as {hi, lo}
  function automatic logic [63:0] model(input md_op_t o, input logic [31:0] av, input logic [31:0] bv);
    longint p;
    int     sa, sb, q, r;
    logic [63:0] u;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        return 64'(p);
      end
      MD_MULTU: begin
        u = {32'b0, av} * {32'b0, bv};
        return u;
      end
      MD_DIV: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      MD_DIVU: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        return {av % bv, av / bv};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one op and returns the cycle index (after E0) at which done was seen, or -1.
  task automatic run_op(input md_op_t o, input logic [31:0] av, input logic [31:0] bv, output int lat);
    exp_q.push_back(model(o, av, bv));
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
  endtask

  task automatic test_reset;
    mfreq = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    mfreq = 1'b0;
  endtask

  task automatic test_mtx;
    op = MD_MTHI; a = 32'h0000_1234; start = 1'b1; mfreq = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall_idle got %b exp 0", stall); end
    @(posedge clk); #1;
    op = MD_MTLO; a = 32'h0000_5678;
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi got %h exp 00001234", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; mfreq = 1'b0;
    checks++; if (lo !== 32'h0000_5678) begin errors++; $display("FAIL mtlo_lo got %h exp 00005678", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 00001234", hi); end
  endtask

  task automatic test_flush;
    int ndone;
    op = MD_MTHI; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL flush_idle_mthi got %h exp 00001234", hi); end
    op = MD_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_start got %b exp 1", busy); end
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_done got %0d pulses exp 0", ndone); end
    checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin
      errors++; $display("FAIL flush_hilo got %h exp 0000123400005678", {hi, lo});
    end
  endtask

  task automatic test_mult_div;
    md_op_t      ops[10] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV, MD_DIVU,
                             MD_MULT, MD_DIV, MD_DIV, MD_MULT, MD_DIVU};
    logic [31:0] va[10]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100,
                             32'd5, 32'd7, 32'hFFFF_FFF0, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[10]  = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0,
                             32'd6, 32'hFFFF_FFFE, 32'd0, 32'h8000_0000, 32'd1};
    int          lat;
    logic [63:0] expv;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], va[i], vb[i], lat);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (lat !== 33) begin errors++; $display("FAIL md%0d_latency got %0d exp 33", i, lat); end
      checks++; if ({hi, lo} !== expv) begin errors++; $display("FAIL md%0d_result got %h exp %h", i, {hi, lo}, expv); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL md%0d_busy got %b exp 0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL md%0d_done_width got %b exp 0", i, done); end
    end
  endtask

  task automatic test_stall_ignore;
    int          nstall, ndone, lat;
    logic        stall33;
    logic [63:0] expv;
    mfreq = 1'b1;
    exp_q.push_back(model(MD_DIVU, 32'd1000, 32'd7));
    op = MD_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nstall = 0; ndone = 0; lat = -1; stall33 = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k == 4) begin op = MD_MULT; a = 32'd3; b = 32'd3; start = 1'b1; end
      if (k == 5) start = 1'b0;
      if (k <= 32 && stall === 1'b1) nstall++;
      if (k == 33) stall33 = stall;
      if (done) begin ndone++; if (lat < 0) lat = k; end
      @(posedge clk); #1;
    end
    mfreq = 1'b0;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if (nstall !== 33) begin errors++; $display("FAIL stall_cycles got %0d exp 33", nstall); end
    checks++; if (stall33 !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", stall33); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d exp 33", lat); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done got %0d pulses exp 1", ndone); end
    checks++; if ({hi, lo} !== expv) begin errors++; $display("FAIL ignore_result got %h exp %h", {hi, lo}, expv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_abort;
    int ndone;
    op = MD_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo got %h exp 0", {hi, lo}); end
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_done got %0d pulses exp 0", ndone); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo_after got %h exp 0", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int          lat;
    md_op_t      o;
    logic [31:0] av, bv;
    logic [63:0] expv;
    for (int i = 0; i < 12; i++) begin
      o  = md_op_t'(3'($urandom_range(0, 3)));
      av = $urandom;
      bv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 0) begin o = MD_DIV; av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
      run_op(o, av, bv, lat);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b%0d_latency got %0d exp 33", i, lat); end
      checks++; if ({hi, lo} !== expv) begin
        errors++; $display("FAIL b2b%0d_result op %0d a %h b %h got %h exp %h", i, o, av, bv, {hi, lo}, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; mfreq = 1'b0;
    op = MD_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_mtx();
    test_flush();
    test_mult_div();
    test_stall_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
